// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with one-entry holding register and valid/ready output
module uart_rx #(
  parameter int BIT_CYCLES = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] recv_data,
  output logic       recv_valid,
  input  logic       recv_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       clr_overrun,
  output logic       busy
);

  // Start bit is confirmed at its midpoint; every later sample lands mid-bit.
  localparam int HALF = BIT_CYCLES / 2;
  localparam int CW   = $clog2(BIT_CYCLES);

  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          rx_meta;
  logic          rx_s;
  logic          stop_point;
  logic          deliver;
  logic          stop_bad;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Stop-bit sample point decides between delivering the byte and flagging a framing error.
  always_comb begin
    stop_point = (state == STOP) && (cnt == CNT_LAST);
    deliver    = stop_point && rx_s;
    stop_bad   = stop_point && !rx_s;
  end

  // Frame sequencer; cnt restarts on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt            <= '0;
            shreg[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
              bit_idx <= 3'd0;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : WAIT_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Holding register: a delivery may replace a byte only when it is consumed in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      recv_data  <= 8'h00;
      recv_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      if (deliver) begin
        if (!recv_valid || recv_ready) begin
          recv_data  <= shreg;
          recv_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (recv_valid && recv_ready) begin
        recv_valid <= 1'b0;
      end
      if (clr_overrun && !(deliver && recv_valid && !recv_ready)) begin
        overrun <= 1'b0;
      end
    end
  end

  // Busy whenever a frame is in progress or a break is being waited out.
  always_comb begin
    busy = (state != IDLE);
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx at 16 clocks per bit
module tb_uart_rx;

  localparam int BC  = 16;
  localparam int LAT = 2 + BC / 2 + 9 * BC;  // E0 to delivery edge = 154

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] recv_data;
  logic       recv_valid;
  logic       recv_ready;
  logic       frame_err;
  logic       overrun;
  logic       clr_overrun;
  logic       busy;

  int n_cmp;
  int n_bad;
  int cyc;
  int e0;
  int rise_cnt;
  int rise_cyc;
  logic [7:0] rise_data;
  int vhi_cnt;
  int fe_cnt;
  int fe_cyc;
  logic prev_v;

  uart_rx #(.BIT_CYCLES(BC)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .recv_data  (recv_data),
    .recv_valid (recv_valid),
    .recv_ready (recv_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .clr_overrun(clr_overrun),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor on the inactive edge: valid rises, valid-high cycles, frame_err pulses.
  always @(negedge clk) begin
    if (rst) begin
      prev_v <= 1'b0;
    end else begin
      prev_v <= recv_valid;
      if (recv_valid && !prev_v) begin
        rise_cnt  <= rise_cnt + 1;
        rise_cyc  <= cyc;
        rise_data <= recv_data;
      end
      if (recv_valid) vhi_cnt <= vhi_cnt + 1;
      if (frame_err) begin
        fe_cnt <= fe_cnt + 1;
        fe_cyc <= cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered and left just after a rising edge; E0 is the next rising edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f  = {stop_bit, b, 1'b0};
    e0 = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (BC) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int b_rise, b_vhi, b_fe;
  logic ok;

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; e0 = 0;
    rise_cnt = 0; rise_cyc = 0; rise_data = 8'h00; vhi_cnt = 0;
    fe_cnt = 0; fe_cyc = 0; prev_v = 1'b0;
    rst = 1'b1; rx = 1'b1; recv_ready = 1'b0; clr_overrun = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", recv_valid, 0);
    check("rst_data", recv_data, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_fe", frame_err, 0);
    check("rst_ovr", overrun, 0);
    rst = 1'b0;
    idle(4);

    // Back-to-back frames, consumer always ready.
    recv_ready = 1'b1;
    b_rise = rise_cnt; b_vhi = vhi_cnt; b_fe = fe_cnt;
    send_frame(8'h55, 1'b1);
    check("t1_55_rise", rise_cnt - b_rise, 1);
    check("t1_55_data", rise_data, 8'h55);
    check("t1_55_lat", rise_cyc - e0, LAT);
    check("t1_55_vhi", vhi_cnt - b_vhi, 1);
    send_frame(8'hA5, 1'b1);
    check("t1_a5_rise", rise_cnt - b_rise, 2);
    check("t1_a5_data", rise_data, 8'hA5);
    check("t1_a5_lat", rise_cyc - e0, LAT);
    check("t1_a5_vhi", vhi_cnt - b_vhi, 2);
    check("t1_fe", fe_cnt - b_fe, 0);
    check("t1_ovr", overrun, 0);
    idle(4);

    // Three-cycle glitch is rejected as a false start.
    b_rise = rise_cnt; b_fe = fe_cnt;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t2_busy_set", busy, 1);
    rx = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("t2_busy_clr", ok, 1);
    @(posedge clk);
    #1;
    idle(4);
    check("t2_rise", rise_cnt - b_rise, 0);
    check("t2_fe", fe_cnt - b_fe, 0);

    // Low stop bit followed by a 40-cycle break: one frame_err, no byte.
    b_rise = rise_cnt; b_fe = fe_cnt;
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("t3_busy_brk", busy, 1);
    idle(6);
    check("t3_fe_cnt", fe_cnt - b_fe, 1);
    check("t3_fe_lat", fe_cyc - e0, LAT);
    check("t3_rise", rise_cnt - b_rise, 0);
    check("t3_valid", recv_valid, 0);
    send_frame(8'h81, 1'b1);
    check("t3_81_rise", rise_cnt - b_rise, 1);
    check("t3_81_data", rise_data, 8'h81);
    idle(4);

    // Overrun: second byte dropped while the first is unread.
    recv_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(2);
    check("t4_valid", recv_valid, 1);
    check("t4_data", recv_data, 8'h11);
    check("t4_ovr", overrun, 1);
    clr_overrun = 1'b1;
    @(posedge clk);
    #1;
    clr_overrun = 1'b0;
    check("t4_ovr_clr", overrun, 0);
    recv_ready = 1'b1;
    @(posedge clk);
    #1;
    recv_ready = 1'b0;
    check("t4_consumed", recv_valid, 0);
    check("t4_data_hold", recv_data, 8'h11);
    idle(4);

    // Consume exactly on the delivery edge of the next byte.
    send_frame(8'h11, 1'b1);
    check("t5_first", recv_data, 8'h11);
    b_rise = rise_cnt;
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (LAT) @(posedge clk);
        #1;
        recv_ready = 1'b1;
        @(posedge clk);
        #1;
        recv_ready = 1'b0;
      end
    join
    check("t5_valid", recv_valid, 1);
    check("t5_data", recv_data, 8'h22);
    check("t5_ovr", overrun, 0);
    check("t5_norise", rise_cnt - b_rise, 0);
    idle(4);

    // Reset in the middle of bit 4 of 0xF0, then receive 0x0F.
    recv_ready = 1'b1;
    b_fe = fe_cnt;
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (5 * BC + 6) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", recv_valid, 0);
        check("t6_rst_data", recv_data, 8'h00);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ovr", overrun, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
      end
    join
    idle(4);
    b_rise = rise_cnt;
    check("t6_idle_valid", recv_valid, 0);
    send_frame(8'h0F, 1'b1);
    check("t6_rise", rise_cnt - b_rise, 1);
    check("t6_data", rise_data, 8'h0F);
    check("t6_fe", fe_cnt - b_fe, 0);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart to the SoC UART transmitter.
- Samples a serial `rx` line (8N1, LSB first) and deserialises bytes into a one-entry holding register.
- Presents the held byte through a valid/ready handshake to the SoC bus peripheral wrapper.
- Flags framing errors and overruns. Used for host-to-SoC console input and for loopback tests against the transmitter.

Parameters:
- BIT_CYCLES, 434, clk cycles per bit (50 MHz / 115200). Must be >= 4; the bench uses 16.
- HALF, BIT_CYCLES/2, derived: mid-bit offset of the start-bit sample. Not to be overridden.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- rx  in  1  serial input; idle high; asynchronous to clk
- recv_data  out  8  received byte; valid while recv_valid=1
- recv_valid  out  1  holding register full
- recv_ready  in  1  consumer accepts the byte when recv_valid && recv_ready
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  sticky: a byte was dropped because the holding register was full
- clr_overrun  in  1  clears overrun
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE, recv_data=0, recv_valid=0, frame_err=0, overrun=0, busy=0, both synchroniser flops=1, bit counter=0, cycle counter=0.
- rx passes through a 2-flop synchroniser (rx_s); the FSM sees only rx_s.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE. Cycle counter cnt is cleared on every state transition.
- IDLE: when rx_s==0, go to START.
- START: when cnt==HALF-1, sample rx_s.
  - rx_s==1: false start (glitch); go to IDLE, nothing recorded.
  - rx_s==0: go to DATA, bit index=0.
- DATA: when cnt==BIT_CYCLES-1, shift rx_s into bit[index] (LSB first) and clear cnt. After index 7, go to STOP.
- STOP: when cnt==BIT_CYCLES-1, sample rx_s.
  - rx_s==1: deliver the byte, go to IDLE.
  - rx_s==0: frame_err=1 for exactly one cycle, byte discarded, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s==1, then go to IDLE. A held-low line (break) yields exactly one frame_err.
- Timing: let E0 be the first clk edge at which rx is low.
  - Byte delivery (recv_valid rising) and frame_err happen at edge E0 + 2 + HALF + 9*BIT_CYCLES.
  - Data bit k is sampled at E0 + 2 + HALF + (k+1)*BIT_CYCLES.
- Delivery when recv_valid==0: load recv_data, set recv_valid=1.
- Delivery when recv_valid==1 and the same cycle has recv_ready==1: old byte consumed, new byte loaded, recv_valid stays 1, no overrun.
- Delivery when recv_valid==1 and recv_ready==0: new byte dropped, recv_data unchanged, overrun set.
- Handshake: recv_valid && recv_ready with no delivery → recv_valid=0 next cycle. recv_data holds its value after consume (not cleared).
- overrun: set has priority over clr_overrun in the same cycle; otherwise clr_overrun clears it.
- A new start bit may begin the cycle after STOP→IDLE; back-to-back frames with no idle gap beyond the stop bit must be received.
- busy = (state != IDLE), combinational from state.
- rst mid-frame: all outputs return immediately to reset values; the partial byte is lost. After release, the receiver resyncs on the next falling edge of rx.

Test Plan (BIT_CYCLES=16):
- Send 0x55 then 0xA5 with recv_ready=1 → recv_valid high one cycle each; recv_data 0x55 then 0xA5; each at E0+2+8+144 relative to its own start edge; frame_err=0, overrun=0.
- Pull rx low for 3 cycles, then high → no recv_valid, no frame_err, busy returns to 0 within 10 cycles.
- Send 0x3C with stop bit low, then hold rx low 40 cycles → exactly one frame_err pulse, recv_valid=0; a following 0x81 frame is received correctly.
- With recv_ready=0, send 0x11 then 0x22 → recv_data=0x11, overrun=1. Pulse clr_overrun → overrun=0. Assert recv_ready → 0x11 consumed, recv_valid=0.
- Hold recv_valid=1 with 0x11, assert recv_ready exactly on the 0x22 delivery cycle → recv_valid stays 1, recv_data=0x22, overrun=0.
- Assert rst during bit 4 of 0xF0, release, send 0x0F → outputs zero during reset, then recv_data=0x0F with no frame_err.
